mmio_port_responder: RTL and testbench

Memory-mapped I/O responder on the processor's data-memory bus. Decodes a 16-byte window, owns the 32-bit output port register, synchronizes the 8-bit input port, and latches input changes into a sticky status flag with an optional interrupt. It also provides an optional free-running cycle counter. It sits beside the data memory; its `hit` output steers the load-data mux between data memory and this block.

---
 rtl/mmio_port_responder_if.sv | 20 ++
 rtl/mmio_port_responder.sv | 97 +++++++++
 tb/tb_mmio_port_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_port_responder_if.sv
// mmio_port_responder_if: data-memory side bus between core and MMIO responder.
// Core drives address/data/strobes; responder returns hit and load data.
interface mmio_port_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        hit;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  ReadData, hit
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output ReadData, hit
    );
endinterface

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: 16-byte MMIO window with output port, synced input port,
// sticky change flag and irq; cycle counter only with MMIO_CYCLE_COUNTER_EN.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_port_responder_if.slave  bus,
    input  logic [7:0]            PortIn,
    output logic [DATA_WIDTH-1:0] PortOut,
    output logic                  irq
);

    localparam logic [1:0] SEL_OUT  = 2'd0;
    localparam logic [1:0] SEL_IN   = 2'd1;
    localparam logic [1:0] SEL_STAT = 2'd2;
    localparam logic [1:0] SEL_CYC  = 2'd3;

    logic [1:0]  sel;
    logic        wr;
    logic        wr_stat;
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  prev;
    logic        change;
    logic        chg;
    logic        ien;
    logic        chg_next;
    logic        ien_next;
    logic [31:0] cycle;
    logic        unused_addr;

    assign unused_addr = ^bus.Address[1:0];
    assign sel         = bus.Address[3:2];
    assign bus.hit     = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign wr          = bus.hit & bus.MemWrite;
    assign wr_stat     = wr && (sel == SEL_STAT);
    assign change      = (sync2 != prev);

    // A new input change beats a same-cycle write-1-to-clear.
    always_comb begin
        chg_next = chg;
        ien_next = ien;
        if (wr_stat) begin
            ien_next = bus.WriteData[1];
            if (bus.WriteData[0]) chg_next = 1'b0;
        end
        if (change) chg_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            PortOut <= '0;
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            chg     <= 1'b0;
            ien     <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr && (sel == SEL_OUT)) PortOut <= bus.WriteData;
            sync1 <= PortIn;
            sync2 <= sync1;
            prev  <= sync2;
            chg   <= chg_next;
            ien   <= ien_next;
            irq   <= chg_next & ien_next;
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!reset)
            cycle <= '0;
        else if (wr && (sel == SEL_CYC))
            cycle <= bus.WriteData;
        else
            cycle <= cycle + 32'd1;
    end
`else
    assign cycle = '0;
`endif

    always_comb begin
        bus.ReadData = '0;
        if (bus.hit && bus.MemRead) begin
            unique case (sel)
                SEL_OUT:  bus.ReadData = PortOut;
                SEL_IN:   bus.ReadData = {24'b0, sync2};
                SEL_STAT: bus.ReadData = {30'b0, ien, chg};
                SEL_CYC:  bus.ReadData = cycle;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: table-driven bus vectors plus hand sequences
// for input sync, sticky flag, counter and reset; load data via a queue.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        reset;
    logic [7:0]  port_in;
    logic [31:0] port_out;
    logic        irq;
    int          total;
    int          bad;
    logic [31:0] exp_q[$];

    mmio_port_responder_if bus ();

    mmio_port_responder #(.BASE_ADDR(BASE), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .PortIn  (port_in),
        .PortOut (port_out),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        w;
        logic        r;
        logic [31:0] rdata;
        logic        hit;
        logic [31:0] pout;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [31:0] wd,
                           input logic w, input logic r);
        bus.Address   = a;
        bus.WriteData = wd;
        bus.MemWrite  = w;
        bus.MemRead   = r;
    endtask

    // Drive a load, queue its expected data, compare when it settles.
    task automatic rd(input string name, input logic [31:0] a,
                      input logic [31:0] exp);
        set_bus(a, 32'h0, 1'b0, 1'b1);
        exp_q.push_back(exp);
        #1;
        chk(name, bus.ReadData, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        set_bus(a, wd, 1'b1, 1'b0);
        tick();
        set_bus(a, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{BASE,        32'hDEADBEEF, 1, 0, 32'h0,        1, 32'hDEADBEEF};
        vecs[1]  = '{BASE,        32'h0,        0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        vecs[2]  = '{BASE + 16,   32'h0,        0, 1, 32'h0,        0, 32'hDEADBEEF};
        vecs[3]  = '{32'h0,       32'h0,        0, 1, 32'h0,        0, 32'hDEADBEEF};
        vecs[4]  = '{BASE + 16,   32'h12345678, 1, 0, 32'h0,        0, 32'hDEADBEEF};
        vecs[5]  = '{32'h0,       32'h87654321, 1, 0, 32'h0,        0, 32'hDEADBEEF};
        vecs[6]  = '{BASE + 3,    32'h0,        0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        vecs[7]  = '{BASE + 4,    32'hFFFFFFFF, 1, 0, 32'h0,        1, 32'hDEADBEEF};
        vecs[8]  = '{BASE + 4,    32'h0,        0, 1, 32'h0,        1, 32'hDEADBEEF};
        vecs[9]  = '{BASE,        32'hCAFEF00D, 1, 1, 32'hDEADBEEF, 1, 32'hCAFEF00D};
        vecs[10] = '{BASE + 1,    32'h0,        0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D};
        vecs[11] = '{BASE + 8,    32'h0,        0, 1, 32'h0,        1, 32'hCAFEF00D};
        vecs[12] = '{BASE + 8,    32'h2,        1, 0, 32'h0,        1, 32'hCAFEF00D};
        vecs[13] = '{BASE + 8,    32'h0,        0, 1, 32'h2,        1, 32'hCAFEF00D};

        reset   = 1'b0;
        port_in = 8'h00;
        set_bus(BASE, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_portout", port_out, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rdata_idle", bus.ReadData, 32'h0);
        chk("rst_hit", {31'b0, bus.hit}, 32'h1);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            set_bus(vecs[i].addr, vecs[i].wdata, vecs[i].w, vecs[i].r);
            exp_q.push_back(vecs[i].rdata);
            #1;
            chk($sformatf("vec%0d_hit", i), {31'b0, bus.hit},
                {31'b0, vecs[i].hit});
            chk($sformatf("vec%0d_rdata", i), bus.ReadData, exp_q.pop_front());
            tick();
            chk($sformatf("vec%0d_portout", i), port_out, vecs[i].pout);
        end
        set_bus(BASE, 32'h0, 1'b0, 1'b0);

        // Input change 0x00 -> 0xA5 before edge N, IEN already set.
        port_in = 8'hA5;
        tick();
        rd("in_n", BASE + 4, 32'h0);
        tick();
        rd("in_n1", BASE + 4, 32'hA5);
        rd("stat_n1", BASE + 8, 32'h2);
        chk("irq_n1", {31'b0, irq}, 32'h0);
        tick();
        rd("stat_n2", BASE + 8, 32'h3);
        chk("irq_n2", {31'b0, irq}, 32'h1);
        wr(BASE + 8, 32'h3);
        rd("stat_w1c", BASE + 8, 32'h2);
        chk("irq_w1c", {31'b0, irq}, 32'h0);

        // Raise CHG, then clear it in the same cycle as a fresh change.
        port_in = 8'h5A;
        tick();
        tick();
        tick();
        rd("stat_set2", BASE + 8, 32'h3);
        chk("irq_set2", {31'b0, irq}, 32'h1);
        port_in = 8'h00;
        tick();
        tick();
        wr(BASE + 8, 32'h3);
        rd("stat_collide", BASE + 8, 32'h3);
        chk("irq_collide", {31'b0, irq}, 32'h1);
        wr(BASE + 8, 32'h3);
        rd("stat_clr2", BASE + 8, 32'h2);
        chk("irq_clr2", {31'b0, irq}, 32'h0);

`ifdef MMIO_CYCLE_COUNTER_EN
        wr(BASE + 12, 32'hFFFF_FFFE);
        rd("cyc0", BASE + 12, 32'hFFFF_FFFE);
        tick();
        rd("cyc1", BASE + 12, 32'hFFFF_FFFF);
        tick();
        rd("cyc_wrap", BASE + 12, 32'h0);
`else
        rd("cyc_off0", BASE + 12, 32'h0);
        wr(BASE + 12, 32'h0000_0005);
        rd("cyc_off1", BASE + 12, 32'h0);
`endif

        // Reset edge with a store and an input change in flight.
        set_bus(BASE, 32'h1111_2222, 1'b1, 1'b0);
        port_in = 8'hFF;
        reset   = 1'b0;
        tick();
        reset = 1'b1;
        set_bus(BASE, 32'h0, 1'b0, 1'b0);
        chk("rst2_portout", port_out, 32'h0);
        chk("rst2_irq", {31'b0, irq}, 32'h0);
        rd("rst2_stat", BASE + 8, 32'h0);
        rd("rst2_in", BASE + 4, 32'h0);
        rd("rst2_cyc", BASE + 12, 32'h0);
        set_bus(BASE, 32'h0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
